core_status_reg: RTL and testbench
==================================

Name: core_status_reg

Overview:
- Processor status register (P) for the Q2A03 core; the state-holding end of the ALU flag interface.
- Drives the current C/V/N/Z to the ALU flag inputs and captures the ALU's updated flags on a commit strobe.
- Also handles flag instructions (CLC/SEC/CLI/SEI/CLV/CLD/SED), PLP/RTI pulls, PHP/BRK/IRQ push byte formation, and interrupt entry.
- Provides the one-instruction-delayed interrupt mask used by the interrupt poll logic.

Parameters:
- RESET_I, 1, value of the I flag and of O_irq_mask_eff after reset.
- DECIMAL_ENABLE, 0, when 0 O_decimal is forced 0; the D bit is still stored, pushed and pulled.

Ports:
- I_clock  input  1  core clock; all state updates on the rising edge.
- I_reset  input  1  asynchronous, active-high reset.
- I_alu_wr  input  1  commit I_alu_* into C/V/N/Z this cycle.
- I_alu_carry  input  1  ALU carry result.
- I_alu_overflow  input  1  ALU overflow result.
- I_alu_sign  input  1  ALU sign result.
- I_alu_zero  input  1  ALU zero result.
- I_flag_op  input  3  0=none, 1=CLC, 2=SEC, 3=CLI, 4=SEI, 5=CLV, 6=CLD, 7=SED.
- I_pull_wr  input  1  load P from I_pull_data (PLP/RTI).
- I_pull_data  input  8  byte read from the stack.
- I_pull_rti  input  1  qualifies I_pull_wr as RTI: the I-mask change takes effect immediately.
- I_int_entry  input  1  interrupt/BRK entry: set I.
- I_insn_done  input  1  instruction-boundary strobe, one cycle per instruction.
- I_push_brk  input  1  B bit value for O_push_data (1 for PHP/BRK, 0 for IRQ/NMI).
- O_carry  output  1  C flag.
- O_overflow  output  1  V flag.
- O_sign  output  1  N flag.
- O_zero  output  1  Z flag.
- O_decimal  output  1  D flag, gated by DECIMAL_ENABLE.
- O_irq_mask  output  1  architectural I flag.
- O_irq_mask_eff  output  1  delayed I flag used for IRQ polling.
- O_push_data  output  8  byte to push: {N,V,1,B,D,I,Z,C}.

Behaviour:
- State and reset
  - State is C, Z, I, D, V, N, plus eff (drives O_irq_mask_eff). Bit 5 is not stored; bit 4 (B) is not stored.
  - On I_reset (asynchronous): C=Z=D=V=N=0, I=RESET_I, eff=RESET_I.
  - All outputs are combinational from state, so zero latency from state to output.
  - O_push_data = {N, V, 1'b1, I_push_brk, D, I, Z, C}. Combinational, so it also follows I_push_brk in the same cycle.
- Per-edge update priority, per bit:
  - I_pull_wr loads N=d[7], V=d[6], D=d[3], I=d[2], Z=d[1], C=d[0]; d[5:4] are ignored. It overrides every other source for all bits.
  - Otherwise, I_int_entry forces I=1.
  - Otherwise, I_flag_op writes only its own target bit.
  - Otherwise, I_alu_wr writes C/V/N/Z from I_alu_*.
  - I_flag_op and I_alu_wr in the same cycle: flag_op wins on its bit; alu_wr still updates the other three of C/V/N/Z.
  - Unselected bits hold their value.
- Delayed mask (eff), evaluated on the same edge:
  - If I_int_entry=1, or I_pull_wr=1 with I_pull_rti=1: eff takes the new I (1, or pulled d[2]).
  - Else if I_insn_done=1: eff takes the OLD I (pre-edge value). A CLI/SEI/PLP that completes on this boundary therefore affects polling only after the next boundary.
  - Otherwise eff holds.
- I_pull_rti without I_pull_wr is ignored.
- Reset asserted mid-instruction: immediate return to reset values. No pending update survives.

Test Plan:
- Reset release: all flags 0, O_irq_mask=1, O_irq_mask_eff=1; O_push_data=8'h24 with I_push_brk=0, 8'h34 with I_push_brk=1.
- I_alu_wr=1 with I_alu_*={C=1,V=1,N=1,Z=0} and I_flag_op=CLC in the same cycle -> C=0, V=1, N=1, Z=0.
- CLI with I_flag_op=3 and I_insn_done in the same cycle -> O_irq_mask=0 next cycle while eff stays 1; next I_insn_done -> eff=0.
- PLP: I_pull_wr=1, I_pull_data=8'hFF, I_pull_rti=0 -> P bits all 1 and O_push_data=8'hEF (B=0); eff unchanged until the next I_insn_done. Repeat with I_pull_data=8'h00 and I_pull_rti=1 -> eff=0 on the same edge.
- I_int_entry=1 together with I_flag_op=CLI -> I=1 and eff=1. Then I_pull_wr=1 with 8'h00 together with I_int_entry=1 -> I=0 (pull wins).
- DECIMAL_ENABLE=0: SED -> O_decimal=0 but O_push_data bit 3 = 1. Assert I_reset mid-sequence -> all state back to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/core_status_reg.sv
// Q2A03 processor status register (P): holds C/Z/I/D/V/N, applies ALU, flag-op, pull and
// interrupt-entry updates, forms the push byte and tracks the one-instruction-delayed I mask.
module core_status_reg #(
  parameter logic RESET_I        = 1'b1,
  parameter bit   DECIMAL_ENABLE = 1'b0
) (
  input  logic       I_clock,
  input  logic       I_reset,
  input  logic       I_alu_wr,
  input  logic       I_alu_carry,
  input  logic       I_alu_overflow,
  input  logic       I_alu_sign,
  input  logic       I_alu_zero,
  input  logic [2:0] I_flag_op,
  input  logic       I_pull_wr,
  input  logic [7:0] I_pull_data,
  input  logic       I_pull_rti,
  input  logic       I_int_entry,
  input  logic       I_insn_done,
  input  logic       I_push_brk,
  output logic       O_carry,
  output logic       O_overflow,
  output logic       O_sign,
  output logic       O_zero,
  output logic       O_decimal,
  output logic       O_irq_mask,
  output logic       O_irq_mask_eff,
  output logic [7:0] O_push_data
);

  typedef enum logic [2:0] {
    OpNone = 3'd0,
    OpClc  = 3'd1,
    OpSec  = 3'd2,
    OpCli  = 3'd3,
    OpSei  = 3'd4,
    OpClv  = 3'd5,
    OpCld  = 3'd6,
    OpSed  = 3'd7
  } flag_op_e;

  logic c_q, z_q, i_q, d_q, v_q, n_q, eff_q;
  logic c_d, z_d, i_d, d_d, v_d, n_d, eff_d;
  flag_op_e flag_op;

  assign flag_op = flag_op_e'(I_flag_op);

  always_comb begin
    c_d = c_q;
    z_d = z_q;
    i_d = i_q;
    d_d = d_q;
    v_d = v_q;
    n_d = n_q;
    if (I_pull_wr) begin
      n_d = I_pull_data[7];
      v_d = I_pull_data[6];
      d_d = I_pull_data[3];
      i_d = I_pull_data[2];
      z_d = I_pull_data[1];
      c_d = I_pull_data[0];
    end else begin
      // Lowest priority first; later writes override earlier ones on the same bit.
      if (I_alu_wr) begin
        c_d = I_alu_carry;
        v_d = I_alu_overflow;
        n_d = I_alu_sign;
        z_d = I_alu_zero;
      end
      unique case (flag_op)
        OpClc:   c_d = 1'b0;
        OpSec:   c_d = 1'b1;
        OpCli:   i_d = 1'b0;
        OpSei:   i_d = 1'b1;
        OpClv:   v_d = 1'b0;
        OpCld:   d_d = 1'b0;
        OpSed:   d_d = 1'b1;
        default: ;
      endcase
      if (I_int_entry) begin
        i_d = 1'b1;
      end
    end
  end

  // Interrupt entry and RTI change the poll mask at once; otherwise it lags by one boundary.
  always_comb begin
    eff_d = eff_q;
    if (I_int_entry || (I_pull_wr && I_pull_rti)) begin
      eff_d = i_d;
    end else if (I_insn_done) begin
      eff_d = i_q;
    end
  end

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      c_q   <= 1'b0;
      z_q   <= 1'b0;
      i_q   <= RESET_I;
      d_q   <= 1'b0;
      v_q   <= 1'b0;
      n_q   <= 1'b0;
      eff_q <= RESET_I;
    end else begin
      c_q   <= c_d;
      z_q   <= z_d;
      i_q   <= i_d;
      d_q   <= d_d;
      v_q   <= v_d;
      n_q   <= n_d;
      eff_q <= eff_d;
    end
  end

  assign O_carry        = c_q;
  assign O_overflow     = v_q;
  assign O_sign         = n_q;
  assign O_zero         = z_q;
  assign O_decimal      = DECIMAL_ENABLE ? d_q : 1'b0;
  assign O_irq_mask     = i_q;
  assign O_irq_mask_eff = eff_q;
  assign O_push_data    = {n_q, v_q, 1'b1, I_push_brk, d_q, i_q, z_q, c_q};

endmodule

// File: tb/tb_core_status_reg.sv
// Randomized scoreboard bench for core_status_reg: a byte-level P model predicts each edge,
// a monitor compares the DUT one step after every clock edge.
module tb_core_status_reg;

  localparam logic RESET_I        = 1'b1;
  localparam bit   DECIMAL_ENABLE = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alu_wr = 0, alu_c = 0, alu_v = 0, alu_n = 0, alu_z = 0;
  logic [2:0] flag_op = 0;
  logic       pull_wr = 0, pull_rti = 0, int_entry = 0, insn_done = 0, push_brk = 0;
  logic [7:0] pull_data = 0;
  logic       o_c, o_v, o_n, o_z, o_d, o_i, o_eff;
  logic [7:0] o_push;

  core_status_reg #(
    .RESET_I        (RESET_I),
    .DECIMAL_ENABLE (DECIMAL_ENABLE)
  ) dut (
    .I_clock        (clk),
    .I_reset        (rst),
    .I_alu_wr       (alu_wr),
    .I_alu_carry    (alu_c),
    .I_alu_overflow (alu_v),
    .I_alu_sign     (alu_n),
    .I_alu_zero     (alu_z),
    .I_flag_op      (flag_op),
    .I_pull_wr      (pull_wr),
    .I_pull_data    (pull_data),
    .I_pull_rti     (pull_rti),
    .I_int_entry    (int_entry),
    .I_insn_done    (insn_done),
    .I_push_brk     (push_brk),
    .O_carry        (o_c),
    .O_overflow     (o_v),
    .O_sign         (o_n),
    .O_zero         (o_z),
    .O_decimal      (o_d),
    .O_irq_mask     (o_i),
    .O_irq_mask_eff (o_eff),
    .O_push_data    (o_push)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] p;   // full P byte, bits 5/4 kept 0 in the model
    logic       eff;
    logic       brk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  logic [7:0] m_p;
  logic       m_eff;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, " C"}, {7'd0, o_c}, {7'd0, e.p[0]});
    check({tag, " Z"}, {7'd0, o_z}, {7'd0, e.p[1]});
    check({tag, " I"}, {7'd0, o_i}, {7'd0, e.p[2]});
    check({tag, " D"}, {7'd0, o_d}, {7'd0, DECIMAL_ENABLE ? e.p[3] : 1'b0});
    check({tag, " V"}, {7'd0, o_v}, {7'd0, e.p[6]});
    check({tag, " N"}, {7'd0, o_n}, {7'd0, e.p[7]});
    check({tag, " eff"}, {7'd0, o_eff}, {7'd0, e.eff});
    check({tag, " push"}, o_push, e.p | 8'h20 | {3'b000, e.brk, 4'h0});
  endtask

  // Monitor: one expected entry per clock edge after reset release.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare_all("edge", e);
      end
    end
  end

  function automatic void model_reset();
    m_p   = {5'b0, RESET_I, 2'b0};
    m_eff = RESET_I;
  endfunction

  // One clock edge: drive inputs at the falling edge and queue the predicted result.
  task automatic cyc(input logic aw, input logic [3:0] nvzc, input logic [2:0] fop,
                     input logic pw, input logic [7:0] pd, input logic rti,
                     input logic ie, input logic done, input logic brk);
    logic [7:0] np;
    logic       old_i;
    int         bitpos [8] = '{0, 0, 0, 2, 2, 6, 3, 3};
    logic       bitval [8] = '{0, 0, 1, 0, 1, 0, 0, 1};
    exp_t       e;
    @(negedge clk);
    alu_wr = aw; {alu_n, alu_v, alu_z, alu_c} = nvzc;
    flag_op = fop; pull_wr = pw; pull_data = pd; pull_rti = rti;
    int_entry = ie; insn_done = done; push_brk = brk;
    old_i = m_p[2];
    np = m_p;
    if (pw) begin
      np = pd & 8'hCF;
    end else begin
      if (aw) begin
        np[7] = nvzc[3]; np[6] = nvzc[2]; np[1] = nvzc[1]; np[0] = nvzc[0];
      end
      if (fop != 3'd0) np[bitpos[fop]] = bitval[fop];
      if (ie) np[2] = 1'b1;
    end
    if (ie || (pw && rti)) m_eff = np[2];
    else if (done)         m_eff = old_i;
    m_p = np;
    e.p = m_p; e.eff = m_eff; e.brk = brk;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic done);
    cyc(0, 4'h0, 3'd0, 0, 8'h00, 0, 0, done, 0);
  endtask

  task automatic drain();
    int budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      check("drain timeout", 8'(exp_q.size()), 8'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    exp_t r;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    // Reset release values, push byte with both B values.
    r.p = m_p; r.eff = m_eff; r.brk = 0;
    compare_all("reset", r);
    check("reset push b0", o_push, 8'h24);
    push_brk = 1; #1;
    check("reset push b1", o_push, 8'h34);
    push_brk = 0;

    // ALU commit with CLC in the same cycle.
    cyc(1, 4'b1101, 3'd1, 0, 8'h00, 0, 0, 0, 0);
    // CLI on a boundary: I drops now, eff one boundary later.
    cyc(0, 4'h0, 3'd3, 0, 8'h00, 0, 0, 1, 0);
    idle(0);
    idle(1);
    // PLP of FF then RTI of 00.
    cyc(0, 4'h0, 3'd0, 1, 8'hFF, 0, 0, 0, 0);
    idle(0);
    idle(1);
    cyc(0, 4'h0, 3'd0, 1, 8'h00, 1, 0, 0, 1);
    // Interrupt entry beats CLI; pull beats interrupt entry.
    cyc(0, 4'h0, 3'd3, 0, 8'h00, 0, 1, 0, 0);
    cyc(0, 4'h0, 3'd0, 1, 8'h00, 0, 1, 0, 0);
    // SED with decimal disabled; RTI qualifier without pull is ignored.
    cyc(0, 4'h0, 3'd7, 0, 8'h00, 0, 0, 1, 1);
    cyc(0, 4'h0, 3'd0, 0, 8'h00, 1, 0, 0, 0);
    drain();
    check("sed push d", {7'd0, o_push[3]}, 8'd1);
    check("sed decimal", {7'd0, o_d}, 8'd0);

    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)), 4'($urandom), 3'($urandom),
          ($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    // Asynchronous reset mid-instruction with a pending update on the inputs.
    cyc(1, 4'b1111, 3'd7, 0, 8'h00, 0, 0, 1, 0);
    drain();
    alu_wr = 1; {alu_n, alu_v, alu_z, alu_c} = 4'b1111; flag_op = 3'd3; insn_done = 1;
    #2;
    rst = 1;
    #1;
    model_reset();
    r.p = m_p; r.eff = m_eff; r.brk = 0;
    compare_all("async rst", r);
    @(negedge clk);
    alu_wr = 0; flag_op = 0; insn_done = 0;
    rst = 0;
    idle(1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
